writeback_regfile: RTL and testbench

// - Consumes the MEM/WB pipeline-register outputs and commits results to the architectural register file.
// - Selects the writeback value, writes it into a 2^ADDR_W x DATA_W register array, and serves the two ID-stage read ports with same-cycle write bypass.
// - Re-exports the committed write (data/addr/enable) for the forwarding unit and counts retired register writes.

---
 rtl/writeback_regfile.sv | 83 ++++++++
 tb/tb_writeback_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file.
// Selects the MEM/WB result, commits it to the register array, serves two
// asynchronous ID read ports with optional same-cycle bypass, re-exports the
// committed write for forwarding and counts retired register writes.
module writeback_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWriteIn,
  input  logic              MemToRegIn,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [DATA_W-1:0] ReadIn,
  input  logic [ADDR_W-1:0] InstrMuxIn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WBData,
  output logic [ADDR_W-1:0] WBRegAddr,
  output logic              WBWriteEn,
  output logic [CNT_W-1:0]  WriteCount
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [Depth];

  // Writeback value select and effective commit enable; r0 and reset suppress the write.
  always_comb begin
    WBData    = MemToRegIn ? ReadIn : ALUResultIn;
    WBRegAddr = InstrMuxIn;
    WBWriteEn = RegWriteIn & (InstrMuxIn != '0) & Reset;
  end

  // Register array: reset clears every entry so no unwritten register reads as X.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs[i] <= '0;
      end
    end else if (WBWriteEn) begin
      regs[InstrMuxIn] <= WBData;
    end
  end

  // Retired-write counter, saturating at all-ones.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      WriteCount <= '0;
    end else if (WBWriteEn && (WriteCount != {CNT_W{1'b1}})) begin
      WriteCount <= WriteCount + CNT_W'(1);
    end
  end

  // Read port 1: r0 is always zero, bypass wins over stored value when enabled.
  always_comb begin
    ReadData1 = '0;
    if (ReadReg1 != '0) begin
      if ((BYPASS != 0) && WBWriteEn && (ReadReg1 == InstrMuxIn)) begin
        ReadData1 = WBData;
      end else begin
        ReadData1 = regs[ReadReg1];
      end
    end
  end

  // Read port 2: resolved independently of port 1.
  always_comb begin
    ReadData2 = '0;
    if (ReadReg2 != '0) begin
      if ((BYPASS != 0) && WBWriteEn && (ReadReg2 == InstrMuxIn)) begin
        ReadData2 = WBData;
      end else begin
        ReadData2 = regs[ReadReg2];
      end
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: a default instance (bypass on, 32-bit counter)
// and a second instance (bypass off, 4-bit counter) share all inputs.
module tb_writeback_regfile;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RegWriteIn;
  logic        MemToRegIn;
  logic [31:0] ALUResultIn;
  logic [31:0] ReadIn;
  logic [4:0]  InstrMuxIn;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;

  logic [31:0] rd1_a, rd2_a, wbd_a, cnt_a;
  logic [4:0]  wba_a;
  logic        we_a;
  logic [31:0] rd1_b, rd2_b, wbd_b;
  logic [4:0]  wba_b;
  logic        we_b;
  logic [3:0]  cnt_b;

  writeback_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(32)) dut_a (
    .Clk(Clk), .Reset(Reset), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .ALUResultIn(ALUResultIn), .ReadIn(ReadIn), .InstrMuxIn(InstrMuxIn),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1_a), .ReadData2(rd2_a),
    .WBData(wbd_a), .WBRegAddr(wba_a), .WBWriteEn(we_a), .WriteCount(cnt_a)
  );

  writeback_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .ALUResultIn(ALUResultIn), .ReadIn(ReadIn), .InstrMuxIn(InstrMuxIn),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1_b), .ReadData2(rd2_b),
    .WBData(wbd_b), .WBRegAddr(wba_b), .WBWriteEn(we_b), .WriteCount(cnt_b)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_we();
    return RegWriteIn && (InstrMuxIn != 5'd0) && Reset;
  endfunction

  function automatic logic [31:0] m_wbd();
    return MemToRegIn ? ReadIn : ALUResultIn;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && m_we() && (a == InstrMuxIn)) return m_wbd();
    return m_regs[a];
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs, then the registered count.
  task automatic cyc(input logic rst, input logic rw, input logic m2r, input logic [31:0] alu,
                     input logic [31:0] rdin, input logic [4:0] dest,
                     input logic [4:0] r1, input logic [4:0] r2);
    @(negedge Clk);
    Reset = rst; RegWriteIn = rw; MemToRegIn = m2r; ALUResultIn = alu;
    ReadIn = rdin; InstrMuxIn = dest; ReadReg1 = r1; ReadReg2 = r2;
    #1;
    exp_q.push_back(m_rd(r1, 1'b1));
    exp_q.push_back(m_rd(r2, 1'b1));
    exp_q.push_back(m_rd(r1, 1'b0));
    exp_q.push_back(m_rd(r2, 1'b0));
    exp_q.push_back(m_wbd());
    exp_q.push_back({27'd0, dest});
    exp_q.push_back({31'd0, m_we()});
    check("rd1_bypass", rd1_a);
    check("rd2_bypass", rd2_a);
    check("rd1_nobypass", rd1_b);
    check("rd2_nobypass", rd2_b);
    check("wbdata", wbd_a);
    check("wbaddr", {27'd0, wba_a});
    check("wbwe", {31'd0, we_a});
    @(posedge Clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
      m_cnt4 = 4'd0;
    end else if (m_we()) begin
      m_regs[dest] = m_wbd();
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
    end
    #1;
    exp_q.push_back(m_cnt);
    exp_q.push_back({28'd0, m_cnt4});
    check("count32", cnt_a);
    check("count4", {28'd0, cnt_b});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
    m_cnt4 = 4'd0;
    Reset = 1'b0; RegWriteIn = 1'b0; MemToRegIn = 1'b0; ALUResultIn = '0;
    ReadIn = '0; InstrMuxIn = '0; ReadReg1 = '0; ReadReg2 = '0;

    // Initial reset, then reset-state reads.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd30);

    // Random writes with random reads.
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
          5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // One-cycle reset then sweep every register.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h5555, 32'h6666, 5'(i), 5'(i), 5'(32 - i));
    end

    // ALU-result write to r5, then read it back.
    cyc(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);

    // Load-data write to r7 with same-cycle read: bypass vs stored value.
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF, 32'h1234, 5'd7, 5'd5, 5'd7);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);

    // Both ports hit the bypass together.
    cyc(1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd12, 5'd12, 5'd12);

    // Write to r0 is discarded, including on the bypass path.
    cyc(1'b1, 1'b1, 1'b0, 32'hAAAA, 32'h0, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd12);

    // Reset coincident with a write to r9 overrides it.
    cyc(1'b1, 1'b1, 1'b0, 32'h9999_0001, 32'h0, 5'd9, 5'd9, 5'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h9999_0002, 32'h0, 5'd9, 5'd9, 5'd9);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd7);

    // First post-reset write commits; then 20 writes saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, 5'(1 + (i % 31)), 5'(1 + (i % 31)), 5'd1);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd20, 5'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
